// File: rtl/lora_chirp_gen.sv
// rtl/lora_chirp_gen.sv - handshaked LoRa chirp frequency-ramp generator
// Optional phase integrator: LORA_CHIRP_PHASE_ACC_EN
`timescale 1ns/1ps
module lora_chirp_gen #(
    parameter int PRECISION = 16,
    parameter int SF_MAX    = 12,
    parameter int SF_MIN    = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [3:0]           sf,
    input  logic                 chirp_type,
    input  logic [PRECISION-1:0] bw_sr,
    input  logic [PRECISION-1:0] phase_inc,
    input  logic                 sym_valid,
    output logic                 sym_ready,
    input  logic [SF_MAX-1:0]    symbol,
    input  logic                 out_ready,
    output logic [PRECISION-1:0] freq_out,
    output logic                 freq_valid,
    output logic                 sym_last,
    output logic                 busy,
    output logic [PRECISION-1:0] phase_acc
);

    localparam int PW = PRECISION + SF_MAX;
    localparam logic [3:0] SF_MIN_L = 4'(SF_MIN);
    localparam logic [3:0] SF_MAX_L = 4'(SF_MAX);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                       state_q, state_d;
    logic                         type_q;
    logic [PRECISION-1:0]         bw_q, inc_q, freq_q;
    logic [SF_MAX-1:0]            cnt_q, mask_q;
    logic                         last_q;

    logic [3:0]                   sf_clamp;
    logic [SF_MAX:0]              one_sh, one_sh_m1;
    logic [SF_MAX-1:0]            mask_new;
    logic [PW-1:0]                prod;
    logic [PRECISION-1:0]         start_val;
    logic signed [PRECISION:0]    cur_x, inc_x, bw_x, sum_x, wrap_x;
    logic                         cnt_is_last, advance, accept;
    logic [SF_MAX-1:0]            cnt_inc;

    // Symbol setup: clamp sf, mask symbol, compute cyclic start frequency
    always_comb begin
        sf_clamp = sf;
        if (sf < SF_MIN_L)
            sf_clamp = SF_MIN_L;
        else if (sf > SF_MAX_L)
            sf_clamp = SF_MAX_L;
        one_sh    = (SF_MAX+1)'(1) << sf_clamp;
        one_sh_m1 = one_sh - (SF_MAX+1)'(1);
        mask_new  = one_sh_m1[SF_MAX-1:0];
        prod      = PW'(symbol & mask_new) * PW'(phase_inc);
        start_val = chirp_type ? (bw_sr - prod[PRECISION-1:0])
                               : (prod[PRECISION-1:0] - bw_sr);
    end

    // One-sample step with wrap into [-bw, +bw], evaluated one bit wider
    always_comb begin
        cur_x  = {freq_q[PRECISION-1], freq_q};
        inc_x  = {1'b0, inc_q};
        bw_x   = {1'b0, bw_q};
        sum_x  = type_q ? (cur_x - inc_x) : (cur_x + inc_x);
        wrap_x = sum_x;
        if (sum_x > bw_x)
            wrap_x = sum_x - (bw_x <<< 1);
        else if (sum_x < -bw_x)
            wrap_x = sum_x + (bw_x <<< 1);
    end

    assign cnt_is_last = (cnt_q == mask_q);
    assign advance     = (state_q == S_RUN) && out_ready;
    assign sym_ready   = !clear && ((state_q == S_IDLE) || (advance && cnt_is_last));
    assign accept      = sym_valid && sym_ready;
    assign cnt_inc     = cnt_q + SF_MAX'(1);

    always_comb begin
        state_d = state_q;
        if (clear)
            state_d = S_IDLE;
        else if (accept)
            state_d = S_RUN;
        else if (advance && cnt_is_last)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            type_q <= 1'b0;
            bw_q   <= '0;
            inc_q  <= '0;
            freq_q <= '0;
            cnt_q  <= '0;
            mask_q <= '0;
            last_q <= 1'b0;
        end else if (clear) begin
            freq_q <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else if (accept) begin
            type_q <= chirp_type;
            bw_q   <= bw_sr;
            inc_q  <= phase_inc;
            mask_q <= mask_new;
            freq_q <= start_val;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else if (advance) begin
            if (cnt_is_last) begin
                last_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_inc;
                freq_q <= wrap_x[PRECISION-1:0];
                last_q <= (cnt_inc == mask_q);
            end
        end
    end

`ifdef LORA_CHIRP_PHASE_ACC_EN
    logic [PRECISION-1:0] phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            phase_q <= '0;
        else if (clear || accept)
            phase_q <= '0;
        else if (advance)
            phase_q <= phase_q + freq_q;
    end

    assign phase_acc = phase_q;
`else
    assign phase_acc = '0;
`endif

    assign freq_out   = freq_q;
    assign freq_valid = (state_q == S_RUN);
    assign busy       = (state_q != S_IDLE);
    assign sym_last   = last_q;

endmodule

// File: tb/tb_lora_chirp_gen.sv
// tb/tb_lora_chirp_gen.sv - self-checking bench for lora_chirp_gen
`timescale 1ns/1ps
module tb_lora_chirp_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  sf = 4'd7;
    logic        chirp_type = 1'b0;
    logic [15:0] bw_sr = 16'd16384;
    logic [15:0] phase_inc = 16'd256;
    logic        sym_valid = 1'b0;
    logic        sym_ready;
    logic [11:0] symbol = '0;
    logic        out_ready = 1'b1;
    logic [15:0] freq_out;
    logic        freq_valid;
    logic        sym_last;
    logic        busy;
    logic [15:0] phase_acc;

    int checks = 0;
    int passes = 0;

    lora_chirp_gen #(.PRECISION(16), .SF_MAX(12), .SF_MIN(7)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .sf(sf),
        .chirp_type(chirp_type), .bw_sr(bw_sr), .phase_inc(phase_inc),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .symbol(symbol),
        .out_ready(out_ready), .freq_out(freq_out), .freq_valid(freq_valid),
        .sym_last(sym_last), .busy(busy), .phase_acc(phase_acc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    endtask

    task automatic tmo(input string name);
        checks++;
        $display("FAIL %s timeout at %0t", name, $time);
    endtask

    // Reference model: symbol-level view of the ramp
    bit          m_run = 1'b0;
    int          m_k = 0, m_L = 128, m_freq = 0, m_bw = 0, m_inc = 0;
    bit          m_type = 1'b0;
    logic [15:0] m_phase = '0;
    int          m_acc_cnt = 0;
    int          ms_sfc, ms_s, ms_st;
    logic signed [15:0] ms_t16;

    function automatic int wrapf(input int x, input int b);
        if (x > b) return x - 2 * b;
        if (x < -b) return x + 2 * b;
        return x;
    endfunction

    function automatic bit m_ready();
        return !clear && (!m_run || (out_ready && m_k == m_L - 1));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            m_run = 1'b0; m_k = 0; m_freq = 0; m_phase = '0;
        end else if (sym_valid && m_ready()) begin
            ms_sfc = (sf < 7) ? 7 : (sf > 12) ? 12 : int'(sf);
            m_L    = 1 << ms_sfc;
            ms_s   = int'(symbol) % m_L;
            ms_st  = chirp_type ? int'(bw_sr) - ms_s * int'(phase_inc)
                                : ms_s * int'(phase_inc) - int'(bw_sr);
            ms_t16 = ms_st[15:0];
            m_freq = ms_t16;
            m_bw = bw_sr; m_inc = phase_inc; m_type = chirp_type;
            m_k = 0; m_run = 1'b1; m_phase = '0;
            m_acc_cnt++;
        end else if (m_run && out_ready) begin
            m_phase = m_phase + 16'(m_freq);
            if (m_k == m_L - 1)
                m_run = 1'b0;
            else begin
                m_k++;
                m_freq = wrapf(m_freq + (m_type ? -m_inc : m_inc), m_bw);
            end
        end
    end

    always @(negedge clk) begin
        chk("freq_valid", freq_valid, m_run);
        chk("busy", busy, m_run);
        chk("sym_last", sym_last, m_run && (m_k == m_L - 1));
        chk("sym_ready", sym_ready, m_ready());
        if (m_run) chk("freq_out", $signed(freq_out), m_freq);
`ifdef LORA_CHIRP_PHASE_ACC_EN
        if (m_run) chk("phase_acc", $signed(phase_acc), $signed(m_phase));
`else
        chk("phase_acc_off", phase_acc, 0);
`endif
    end

    task automatic send(input bit ty, input int sy, input logic [3:0] sfv, input bit hold);
        int c0;
        c0 = m_acc_cnt;
        chirp_type = ty; symbol = 12'(sy); sf = sfv; sym_valid = 1'b1;
        for (int i = 0; i < 6000 && m_acc_cnt == c0; i++) begin
            @(posedge clk); #1;
        end
        if (m_acc_cnt == c0) tmo("send");
        if (!hold) sym_valid = 1'b0;
    endtask

    task automatic wait_k(input int k);
        for (int i = 0; i < 6000 && !(m_run && m_k == k); i++) begin
            @(posedge clk); #1;
        end
        if (!(m_run && m_k == k)) tmo("wait_k");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 6000 && m_run; i++) begin
            @(posedge clk); #1;
        end
        if (m_run) tmo("wait_idle");
    endtask

    task automatic lit(input string name, input int v);
        chk({name, "_dut"}, $signed(freq_out), v);
        chk({name, "_model"}, m_freq, v);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_freq_out", freq_out, 0);
        chk("rst_freq_valid", freq_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sym_last", sym_last, 0);
        chk("rst_phase_acc", phase_acc, 0);
        chk("rst_sym_ready", sym_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: up-chirp, symbol 0
        send(1'b0, 0, 4'd7, 1'b0);
        lit("t1_s0", -16384);
        wait_k(1);   lit("t1_s1", -16128);
        wait_k(2);
`ifdef LORA_CHIRP_PHASE_ACC_EN
        chk("t1_phase2", $signed(phase_acc), -32512);
`endif
        wait_k(127); lit("t1_s127", 16128);
        chk("t1_last", sym_last, 1);
        wait_idle();

        // 2: up-chirp, symbol 64, with mid-symbol input changes
        send(1'b0, 64, 4'd7, 1'b0);
        lit("t2_s0", 0);
        wait_k(30);
        bw_sr = 16'd1000; phase_inc = 16'd77; chirp_type = 1'b1; sf = 4'd9;
        wait_k(64);  lit("t2_s64", 16384);
        wait_k(65);  lit("t2_s65", -16128);
        wait_k(127); lit("t2_s127", -256);
        wait_idle();
        bw_sr = 16'd16384; phase_inc = 16'd256;

        // 3: down-chirps
        send(1'b1, 0, 4'd7, 1'b0);
        lit("t3a_s0", 16384);
        wait_k(127); lit("t3a_s127", -16128);
        wait_idle();
        send(1'b1, 1, 4'd7, 1'b0);
        lit("t3b_s0", 16128);
        wait_k(127); lit("t3b_s127", -16384);
        wait_idle();

        // 4: back-to-back symbols 0 then 5
        send(1'b0, 0, 4'd7, 1'b1);
        symbol = 12'd5;
        send(1'b0, 5, 4'd7, 1'b0);
        lit("t4_s0", -15104);
        chk("t4_valid", freq_valid, 1);
        wait_idle();

        // 5: stall at sample 10
        send(1'b0, 0, 4'd7, 1'b0);
        wait_k(10);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t5_hold", $signed(freq_out), -13824);
        end
        out_ready = 1'b1;
        wait_k(11); lit("t5_s11", -13568);
        wait_idle();

        // sf clamping: 2 -> 7, 15 -> 12
        send(1'b0, 3, 4'd2, 1'b0);
        lit("clamp_lo_s0", -15616);
        wait_k(127);
        chk("clamp_lo_last", sym_last, 1);
        wait_idle();
        phase_inc = 16'd8;
        send(1'b0, 1, 4'd15, 1'b0);
        lit("clamp_hi_s0", -16376);
        wait_k(4095); lit("clamp_hi_s4095", 16384);
        chk("clamp_hi_last", sym_last, 1);
        wait_idle();
        phase_inc = 16'd256;

        // 6: clear at sample 40, then reset pulse mid-symbol
        send(1'b0, 0, 4'd7, 1'b0);
        wait_k(40);
        clear = 1'b1;
        #3;
        chk("t6_clr_ready", sym_ready, 0);
        @(posedge clk); #1;
        clear = 1'b0;
        chk("t6_clr_valid", freq_valid, 0);
        chk("t6_clr_busy", busy, 0);
        chk("t6_clr_freq", freq_out, 0);
        chk("t6_clr_last", sym_last, 0);
        chk("t6_clr_phase", phase_acc, 0);
        send(1'b0, 0, 4'd7, 1'b0);
        lit("t6_restart", -16384);
        wait_k(20);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_valid", freq_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_phase", phase_acc, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(1'b0, 0, 4'd7, 1'b0);
        lit("t6_rst_restart", -16384);
        wait_idle();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
